fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the byte FIFO from its receive side and shifts each word out as an asynchronous start/data/stop frame. It sits directly downstream of `fifo`. It pulls words with the FIFO's four-phase `rx_rdy`/`rx_done` handshake and drives a single idle-high serial line, LSB first.

## Interface
- `WIDTH`, 8, data bits per frame; must match the FIFO word width.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_rdy`  in  1  connects to FIFO `rx_rdy`; high means `fifo_data` is valid.
- `fifo_data`  in  WIDTH  connects to FIFO `out_data`.
- `fifo_done`  out  1  connects to FIFO `rx_done`; acknowledge for the four-phase handshake.
- `tx`  out  1  serial line; idles at 1.
- `busy`  out  1  high while a frame is on the line (START through STOP).

## Operation
- Reset values: `tx`=1, `fifo_done`=0, `busy`=0, state=IDLE, shift register and counters = 0.
- **IDLE:** if `fifo_rdy`=1 and `fifo_done`=0:
  - latch `fifo_data` into the shift register;
  - set `fifo_done`=1;
  - go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx` = shift[0] for `CLKS_PER_BIT` cycles per bit; shift right after each bit.
  - After `WIDTH` bits go to PARITY if the macro is enabled, otherwise go to STOP.
- **PARITY:** `tx` = XOR of the latched word (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then return to IDLE.
- Handshake release runs independently of the frame state:
  - while `fifo_done`=1, it clears on the first cycle `fifo_rdy` is sampled 0;
  - if `fifo_rdy` stays high, `fifo_done` stays high and no new word is accepted.
- Counters:
  - bit-period counter width is `$clog2(CLKS_PER_BIT)`; it counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary;
  - bit index width is `$clog2(WIDTH+1)`.
- `fifo_data` is sampled only at the accept edge; later changes have no effect on the frame in flight.
- An empty FIFO (`fifo_rdy` low) holds the block in IDLE with `tx`=1 indefinitely.
- Reset mid-frame:
  - `tx` returns to 1 immediately (asynchronous), `fifo_done` and `busy` go to 0, and the partial frame is abandoned;
  - the word already acknowledged is lost, which is the accepted behaviour.

## Timing
- Accept edge E: `fifo_rdy`=1 is sampled in IDLE. `fifo_done`, `busy`, and `tx`=0 all become visible after E (registered outputs, one-cycle latency).
- Frame length F = (`WIDTH`+2)·`CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` when parity is enabled.
- The block spends at least one cycle in IDLE between frames. Back-to-back period is therefore F+1 cycles, provided the FIFO has completed its handshake (`fifo_rdy` low then high again) before STOP ends.
- `fifo_done` falls one cycle after `fifo_rdy` is sampled low. It never falls while `fifo_rdy`=1.
- `busy` falls on the same edge the state returns to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Frames carry one even-parity bit after the data bits, giving F = (`WIDTH`+3)·`CLKS_PER_BIT`.
- Not defined: the PARITY state and its logic are absent, and STOP follows the last data bit directly.

## Test plan
- **Single word:** `CLKS_PER_BIT`=4, push 0xA5, raise `fifo_rdy` → line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; `busy` high for exactly 40 cycles; `tx`=1 afterward.
- **Handshake:** `fifo_rdy` held high 10 cycles after accept → `fifo_done` stays 1 for all 10 and there is no second accept. Then drop `fifo_rdy` → `fifo_done`=0 one cycle later.
- **Back-to-back:** FIFO pre-filled with 0x00, 0xFF, 0x3C → three frames with start-bit edges exactly 41 cycles apart (`CLKS_PER_BIT`=4) and data bits matching each word LSB first.
- **Reset mid-frame:** assert `rst_n`=0 during the data bit 3 of 0x5A → `tx`=1 and `fifo_done`=0 immediately. After release, the next word 0x81 transmits cleanly.
- **Parity (macro defined):** 0x07 → parity bit 1; 0x03 → parity bit 0; each frame spans 44 cycles at `CLKS_PER_BIT`=4.
- **Empty FIFO:** `fifo_rdy` low for 200 cycles → `tx`=1, `busy`=0, `fifo_done`=0 throughout.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pulls words from a four-phase FIFO receive port and sends each as an idle-high start/data/stop frame, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_rdy,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_done,
    output logic             tx,
    output logic             busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic             accept;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // A new word is taken only once the previous handshake has fully released.
    assign accept     = (state == S_IDLE) && fifo_rdy && !fifo_done;
    assign bit_end    = (cnt == CNT_LAST);
    assign shift_next = shift >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (accept) begin
                        shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_data;
`endif
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= shift[0];
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // tx is registered, so it takes the bit that becomes shift[0] now
                            idx   <= idx + 1'b1;
                            shift <= shift_next;
                            tx    <= shift_next[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    idx   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake release is independent of the frame: done drops on the first low rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_done <= 1'b0;
        end else if (fifo_done) begin
            if (!fifo_rdy) begin
                fifo_done <= 1'b0;
            end
        end else if (accept) begin
            fifo_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLKS_PER_BIT=4: table-driven frames, hand-written corner sequences,
// and randomized words checked cycle by cycle against a bit-period model of the serial line.
module tb_fifo_uart_tx;
    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int NTBL  = 10;

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_rdy = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_done;
    logic       tx;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic busy_q = 1'b0;
    int starts[$];

    fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_rdy(fifo_rdy),
        .fifo_data(fifo_data),
        .fifo_done(fifo_done),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) starts.push_back(cyc);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line level during cycle k of a frame carrying word w.
    function automatic logic model_line(input logic [7:0] w, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= WIDTH) return w[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == WIDTH + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    function automatic logic [10:0] model_seq(input logic [7:0] w);
        logic [10:0] s;
        s = '0;
        for (int b = 0; b < NBITS; b++) s[b] = model_line(w, b * CPB);
        return s;
    endfunction

    function automatic logic [10:0] table_seq(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    // Offers w, holds rdy for h cycles after the accept edge, and checks every cycle.
    task automatic run_frame(input logic [7:0] w, input int h, input logic [10:0] seq, input string tag);
        logic exp_done;
        int   total;
        total = (h + 2 > FRAME) ? h + 2 : FRAME;
        fifo_data = w;
        fifo_rdy  = 1'b1;
        @(posedge clk); #1;
        exp_done = 1'b1;
        for (int k = 0; k <= total; k++) begin
            if (k < FRAME) begin
                check1({tag, " tx"}, tx, seq[k / CPB]);
                check1({tag, " busy"}, busy, 1'b1);
            end else begin
                check1({tag, " tx idle"}, tx, 1'b1);
                check1({tag, " busy idle"}, busy, 1'b0);
            end
            check1({tag, " done"}, fifo_done, exp_done);
            fifo_data = 8'($urandom);
            fifo_rdy  = (k + 1 <= h);
            exp_done  = exp_done & fifo_rdy;
            if (k < total) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        vec_t        tbl[NTBL];
        logic [7:0]  w;
        int          h;
        int          gap;

        tbl[0] = '{8'hA5, 1,  10'h34A, 1'b0};
        tbl[1] = '{8'h3C, 10, 10'h278, 1'b0};
        tbl[2] = '{8'h00, 1,  10'h200, 1'b0};
        tbl[3] = '{8'hFF, 2,  10'h3FE, 1'b0};
        tbl[4] = '{8'h3C, 3,  10'h278, 1'b0};
        tbl[5] = '{8'h07, 1,  10'h20E, 1'b1};
        tbl[6] = '{8'h03, 1,  10'h206, 1'b0};
        tbl[7] = '{8'h01, FRAME + 4, 10'h202, 1'b1};
        tbl[8] = '{8'h5A, 0,  10'h2B4, 1'b0};
        tbl[9] = '{8'h81, 1,  10'h302, 1'b0};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset tx", tx, 1'b1);
        check1("reset done", fifo_done, 1'b0);
        check1("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty FIFO keeps the line idle
        for (int i = 0; i < 200; i++) begin
            check1("empty tx", tx, 1'b1);
            check1("empty busy", busy, 1'b0);
            check1("empty done", fifo_done, 1'b0);
            @(posedge clk); #1;
        end

        starts.delete();
        for (int i = 0; i < NTBL; i++) begin
            run_frame(tbl[i].data, tbl[i].hold, table_seq(tbl[i]), $sformatf("tbl%0d", i));
        end
        check_int("accept count", starts.size(), NTBL);
        if (starts.size() >= 5) begin
            check_int("b2b spacing 00->FF", starts[3] - starts[2], FRAME + 1);
            check_int("b2b spacing FF->3C", starts[4] - starts[3], FRAME + 1);
        end

        // Reset during data bit 3 of 0x5A
        fifo_data = 8'h5A;
        fifo_rdy  = 1'b1;
        @(posedge clk); #1;
        repeat (3 * CPB + 1) @(posedge clk);
        #1;
        check1("midrst bit2 tx", tx, 1'b0);
        repeat (CPB) @(posedge clk);
        #1;
        check1("midrst bit3 tx", tx, 1'b1);
        check1("midrst pre done", fifo_done, 1'b1);
        check1("midrst pre busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("midrst tx", tx, 1'b1);
        check1("midrst done", fifo_done, 1'b0);
        check1("midrst busy", busy, 1'b0);
        fifo_rdy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("post rst tx", tx, 1'b1);
        run_frame(8'h81, 1, model_seq(8'h81), "after_rst");

        // Randomized words, hold times and idle gaps
        for (int n = 0; n < 40; n++) begin
            w   = 8'($urandom);
            h   = $urandom_range(0, FRAME + 6);
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                check1("gap tx", tx, 1'b1);
                check1("gap busy", busy, 1'b0);
                @(posedge clk); #1;
            end
            run_frame(w, h, model_seq(w), $sformatf("rnd%0d_%02h", n, w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
